// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures register write-backs and stores with a cycle stamp
// and presents them in commit order to a ready/valid consumer.
module commit_trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CYC_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wb_en_i,
  input  logic [4:0]                 wb_addr_i,
  input  logic [31:0]                wb_data_i,
  input  logic                       st_en_i,
  input  logic [31:0]                st_addr_i,
  input  logic [31:0]                st_data_i,
  input  logic                       trace_ready_i,
  output logic                       trace_valid_o,
  output logic                       trace_kind_o,
  output logic [31:0]                trace_addr_o,
  output logic [31:0]                trace_data_o,
  output logic [CYC_W-1:0]           trace_cycle_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             kind;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [CYC_W-1:0] cyc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CYC_W-1:0] cyc_q;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             wb_ev, pop, wb_acc, st_acc;
  logic [CNT_W-1:0] free;
  logic [1:0]       n_push, n_drop;
  logic [8:0]       drop_sum;
  logic             we0, we1;
  entry_t           wb_ent, st_ent, ent0;

  // Slot arbitration: the register entry always wins the last free slot.
  always_comb begin
    wb_ev      = wb_en_i & (wb_addr_i != 5'd0);
    pop        = (count_q != '0) & trace_ready_i;
    free       = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
    wb_acc     = wb_ev & (free != '0);
    st_acc     = st_en_i & (wb_acc ? (free >= CNT_W'(2)) : (free != '0));
    n_push     = {1'b0, wb_acc} + {1'b0, st_acc};
    n_drop     = {1'b0, wb_ev & ~wb_acc} + {1'b0, st_en_i & ~st_acc};
    drop_sum   = {1'b0, drop_cnt_q} + 9'(n_drop);
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    overflow_d = overflow_q | (n_drop != 2'd0);
    count_d    = count_q + CNT_W'(n_push) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);

    wb_ent = '{kind: 1'b0, addr: 32'(wb_addr_i), data: wb_data_i, cyc: cyc_q};
    st_ent = '{kind: 1'b1, addr: st_addr_i, data: st_data_i, cyc: cyc_q};
    ent0   = wb_acc ? wb_ent : st_ent;
    we0    = wb_acc | st_acc;
    we1    = wb_acc & st_acc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_q      <= cyc_q + CYC_W'(1);
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (!rst_i && we0) mem_q[wr_ptr_q] <= ent0;
    if (!rst_i && we1) mem_q[wr_ptr_q + PTR_W'(1)] <= st_ent;
  end

  entry_t head;
  assign head          = mem_q[rd_ptr_q];
  assign trace_valid_o = (count_q != '0);
  assign trace_kind_o  = head.kind;
  assign trace_addr_o  = head.addr;
  assign trace_data_o  = head.data;
  assign trace_cycle_o = head.cyc;
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo with hand-computed expectations.
module tb_commit_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en, st_en, ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, st_addr, st_data;
  logic        valid, kind, overflow;
  logic [31:0] t_addr, t_data;
  logic [15:0] t_cyc;
  logic [4:0]  count;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;
  int tb_cyc = 0;
  int stamp;

  always #5 clk = ~clk;

  commit_trace_fifo #(.DEPTH(16), .CYC_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .st_en_i(st_en), .st_addr_i(st_addr), .st_data_i(st_data),
    .trace_ready_i(ready), .trace_valid_o(valid), .trace_kind_o(kind),
    .trace_addr_o(t_addr), .trace_data_o(t_data), .trace_cycle_o(t_cyc),
    .count_o(count), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; tb_cyc mirrors the stamp of the cycle now being entered.
  task automatic step();
    @(posedge clk);
    if (rst) tb_cyc = 0; else tb_cyc++;
    #1;
  endtask

  task automatic idle();
    wb_en = 0; st_en = 0; ready = 0; rst = 0;
    wb_addr = 0; wb_data = 0; st_addr = 0; st_data = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      wb_en = 1; wb_addr = 5'((i % 31) + 1); wb_data = 32'(100 + i);
      step();
    end
    wb_en = 0;
  endtask

  task automatic dual(input logic [4:0] ra, input logic [31:0] rd,
                      input logic [31:0] sa, input logic [31:0] sd);
    wb_en = 1; wb_addr = ra; wb_data = rd;
    st_en = 1; st_addr = sa; st_data = sd;
    step();
    wb_en = 0; st_en = 0;
  endtask

  initial begin
    idle();
    rst = 1; step(); step();
    rst = 0;
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);

    // single write-back in cycle 3
    step(); step(); step();
    wb_en = 1; wb_addr = 5; wb_data = 7;
    step();
    wb_en = 0;
    chk("wb_valid", valid, 1);
    chk("wb_kind", kind, 0);
    chk("wb_addr", t_addr, 5);
    chk("wb_data", t_data, 7);
    chk("wb_cycle", t_cyc, 3);
    chk("wb_count", count, 1);
    step(); step();
    chk("hold_data", t_data, 7);
    chk("hold_cycle", t_cyc, 3);
    ready = 1; step(); ready = 0;
    chk("pop_count", count, 0);
    chk("pop_valid", valid, 0);
    ready = 1; step(); ready = 0;
    chk("empty_ready_count", count, 0);

    // write-back to r0 is ignored
    wb_en = 1; wb_addr = 0; wb_data = 32'hDEAD;
    step(); wb_en = 0;
    chk("r0_count", count, 0);
    chk("r0_ovf", overflow, 0);

    // dual event, register first then store, same stamp
    stamp = tb_cyc;
    dual(2, 10, 8, 99);
    chk("dual_count", count, 2);
    chk("dual0_kind", kind, 0);
    chk("dual0_addr", t_addr, 2);
    chk("dual0_data", t_data, 10);
    chk("dual0_cyc", t_cyc, 32'(stamp));
    ready = 1; step();
    chk("dual1_count", count, 1);
    chk("dual1_kind", kind, 1);
    chk("dual1_addr", t_addr, 8);
    chk("dual1_data", t_data, 99);
    chk("dual1_cyc", t_cyc, 32'(stamp));
    step(); ready = 0;
    chk("dual_drain", count, 0);

    // 15 queued + dual: store dropped
    do_reset();
    fill(15);
    chk("fill15", count, 15);
    dual(20, 555, 32'h40, 666);
    chk("one_slot_count", count, 16);
    chk("one_slot_drop", drop_cnt, 1);
    chk("one_slot_ovf", overflow, 1);

    // 16 queued + dual: both dropped; then push+pop while full
    do_reset();
    fill(16);
    chk("fill16", count, 16);
    dual(21, 1, 32'h44, 2);
    chk("full_count", count, 16);
    chk("full_drop", drop_cnt, 2);
    chk("full_ovf", overflow, 1);
    chk("full_head", t_data, 100);
    ready = 1; wb_en = 1; wb_addr = 9; wb_data = 32'h900;
    step(); wb_en = 0;
    chk("pushpop_count", count, 16);
    chk("pushpop_drop", drop_cnt, 2);
    chk("pushpop_head", t_data, 101);
    // drain to 5 entries; pointers wrap along the way
    for (int i = 0; i < 11; i++) step();
    ready = 0;
    chk("drain5_count", count, 5);
    chk("drain5_head", t_data, 112);
    chk("sticky_ovf", overflow, 1);

    // reset mid-operation, events in the reset cycle are discarded
    rst = 1; wb_en = 1; wb_addr = 4; wb_data = 44;
    step(); rst = 0;
    wb_en = 1; wb_addr = 3; wb_data = 32'h33;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    step(); wb_en = 0;
    chk("post_rst_cycle", t_cyc, 0);
    chk("post_rst_data", t_data, 32'h33);
    chk("post_rst_count", count, 1);

    // drop counter saturation
    fill(15);
    for (int i = 0; i < 130; i++) dual(7, 1, 32'h80, 2);
    chk("sat_drop", drop_cnt, 255);
    chk("sat_count", count, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
